// File: rtl/imem_loader.sv
// imem_loader: small instruction memory filled from a slow nibble-serial host
// port. Two asynchronous host pins (load_req, nib_strobe) are synchronized into
// clk. A CLEAR pass zeroes the array after reset. Pairs of nibbles (low half
// first) are packed into 8-bit words while load mode is held. The core reads
// the array combinationally, and only while the loader is in RUN.
module imem_loader #(
  parameter int  IMEM_SZ = 16,
  localparam int AW      = $clog2(IMEM_SZ),
  localparam int LW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          nib_strobe,
  input  logic [3:0]    nib_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          core_run,
  output logic          busy,
  output logic [LW-1:0] prog_len,
  output logic          ovf_err
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LO    = 2'd2,
    HI    = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_SZ - 1);
  localparam logic [LW-1:0] FULL_LEN  = LW'(IMEM_SZ);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    lo_nib;

  // Synchronizer stages. strb_d is one extra stage, used only to find the rising edge.
  logic load_s1, load_s2;
  logic strb_s1, strb_s2, strb_d;
  logic strobe_evt;

  // Single memory write port
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem [IMEM_SZ];

  // Double-flop both asynchronous pins and delay the strobe once more for edge detection
  // NOTE: sequential state is always assigned with <=. Every flop then samples
  // pre-edge values, and the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_s1 <= 1'b0;
      load_s2 <= 1'b0;
      strb_s1 <= 1'b0;
      strb_s2 <= 1'b0;
      strb_d  <= 1'b0;
    end else begin
      load_s1 <= load_req;
      load_s2 <= load_s1;
      strb_s1 <= nib_strobe;
      strb_s2 <= strb_s1;
      strb_d  <= strb_s2;
    end
  end

  assign strobe_evt = strb_s2 & ~strb_d;

  // Control FSM: clear sweep, idle run, and the low/high nibble load sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      wr_ptr   <= '0;
      prog_len <= '0;
      ovf_err  <= 1'b0;
      lo_nib   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (wr_ptr == LAST_ADDR) begin
            wr_ptr <= '0;
            state  <= RUN;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        RUN: begin
          if (load_s2) begin
            wr_ptr   <= '0;
            prog_len <= '0;
            ovf_err  <= 1'b0;
            state    <= LO;
          end
        end
        LO: begin
          if (!load_s2) begin
            state <= RUN;
          end else if (strobe_evt) begin
            if (prog_len == FULL_LEN) begin
              ovf_err <= 1'b1;
            end else begin
              lo_nib <= nib_data;
              state  <= HI;
            end
          end
        end
        HI: begin
          // Exit takes priority: a strobe in the same cycle as load_req low is dropped.
          if (!load_s2) begin
            state <= RUN;
          end else if (strobe_evt) begin
            prog_len <= prog_len + 1'b1;
            if (wr_ptr != LAST_ADDR) wr_ptr <= wr_ptr + 1'b1;
            state <= LO;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Write-port request: zero fill while clearing, or a packed word on the high nibble
  // NOTE: every output of this block gets a default first. Otherwise, paths
  // that do not assign a signal would hold its old value and infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = 8'h00;
    if (state == CLEAR) begin
      mem_we = 1'b1;
    end else if (state == HI && load_s2 && strobe_evt) begin
      mem_we    = 1'b1;
      mem_wdata = {nib_data, lo_nib};
    end
  end

  // Storage array, one write port
  // NOTE: the array has no reset branch, so it can map onto plain RAM or
  // register storage. The CLEAR sweep after every reset gives it known contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign core_run = (state == RUN);
  assign busy     = (state != RUN);
  assign rd_data  = core_run ? mem[rd_addr] : 8'h00;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed load sequences plus random nibble streams.
// Results are compared against a word-level model of the expected program memory.
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       load_req;
  logic       nib_strobe;
  logic [3:0] nib_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       core_run;
  logic       busy;
  logic [4:0] prog_len;
  logic       ovf_err;

  imem_loader #(.IMEM_SZ(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .nib_strobe (nib_strobe),
    .nib_data   (nib_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .core_run   (core_run),
    .busy       (busy),
    .prog_len   (prog_len),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected memory image and status, as seen from the host
  logic [7:0] model_mem [16];
  int         model_len;
  logic       model_ovf;
  logic [3:0] nib_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Count clocks until busy drops (after reset release); the count must be exactly 16
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, 16);
    @(negedge clk);
  endtask

  // After load_req falls, core_run must come back within 3 clocks
  task automatic wait_run(input string tag);
    int n = 0;
    while (!core_run && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, (core_run && n <= 3) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  // Read every word through the fetch port and compare it with the model
  task automatic verify_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("%s_rd%0d", tag, a), rd_data, model_mem[a]);
    end
    check({tag, "_len"}, prog_len, model_len);
    check({tag, "_ovf"}, ovf_err, model_ovf);
  endtask

  task automatic send_nibble(input logic [3:0] n);
    nib_data   = n;
    nib_strobe = 1'b1;
    repeat (6) @(negedge clk);
    nib_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic enter_load(input string tag);
    load_req = 1'b1;
    repeat (4) @(negedge clk);
    rd_addr = 4'd0;
    #1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_run"}, core_run, 0);
    check({tag, "_gated"}, rd_data, 8'h00);
  endtask

  // Full load of nib_q, then update the model from the loading rules:
  // nibbles pair up low-then-high, at most 16 words are stored, any odd
  // trailing nibble is lost, and any nibble beyond 32 raises ovf_err.
  task automatic run_load(input string tag);
    int n;
    int words;
    enter_load(tag);
    foreach (nib_q[i]) send_nibble(nib_q[i]);
    load_req = 1'b0;
    wait_run({tag, "_exit"});
    n     = nib_q.size();
    words = (n / 2 > 16) ? 16 : n / 2;
    for (int w = 0; w < words; w++) model_mem[w] = {nib_q[2*w+1], nib_q[2*w]};
    model_len = words;
    model_ovf = (n > 32);
    verify_mem(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_req   = 1'b0;
    nib_strobe = 1'b0;
    nib_data   = 4'h0;
    rd_addr    = 4'h0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_run", core_run, 0);
    check("rst_rd", rd_data, 8'h00);
    check("rst_len", prog_len, 0);
    check("rst_ovf", ovf_err, 0);

    // Reset release: CLEAR sweep, then an all-zero memory
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_clear("clear_cycles");
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    model_len = 0;
    model_ovf = 1'b0;
    verify_mem("init");

    // Basic two-word load
    nib_q = '{4'hB, 4'h1, 4'h7, 4'h1};
    run_load("basic");
    check("basic_w0", model_mem[0], 8'h1B);
    check("basic_w1", model_mem[1], 8'h17);

    // Overflow: 33 random nibbles
    nib_q.delete();
    for (int i = 0; i < 33; i++) nib_q.push_back(4'($urandom_range(0, 15)));
    run_load("ovf");

    // Odd nibble count: the trailing low half is discarded
    nib_q = '{4'hA, 4'h5, 4'hC};
    run_load("odd");
    check("odd_w0", model_mem[0], 8'h5A);

    // Exit and strobe reach the controller in the same cycle: the exit must win
    enter_load("race");
    send_nibble(4'h3);
    nib_data   = 4'hF;
    nib_strobe = 1'b1;
    load_req   = 1'b0;
    wait_run("race_exit");
    repeat (4) @(negedge clk);
    nib_strobe = 1'b0;
    model_len  = 0;
    model_ovf  = 1'b0;
    verify_mem("race");

    // Random-length loads
    for (int r = 0; r < 2; r++) begin
      nib_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++)
        nib_q.push_back(4'($urandom_range(0, 15)));
      run_load($sformatf("rand%0d", r));
    end

    // Strobes outside load mode are ignored
    for (int i = 0; i < 3; i++) begin
      send_nibble(4'($urandom_range(0, 15)));
      check($sformatf("idle_run%0d", i), core_run, 1);
    end
    verify_mem("idle");

    // Asynchronous reset in the middle of a load
    enter_load("abort");
    send_nibble(4'h9);
    send_nibble(4'h6);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1);
    check("abort_run", core_run, 0);
    check("abort_rd", rd_data, 8'h00);
    check("abort_len", prog_len, 0);
    check("abort_ovf", ovf_err, 0);
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_clear("abort_clear");
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    model_len = 0;
    model_ovf = 1'b0;
    verify_mem("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: IMEM_SZ, 16, number of 8-bit instruction words held (power of two, address width 4).
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: load_req  in  1  asynchronous pin, level; 1 requests program-load mode.
REQ-005 Port: nib_strobe  in  1  asynchronous pin; each rising edge delivers one nibble.
REQ-006 Port: nib_data  in  4  nibble value, held stable by the host ≥3 clk cycles after each nib_strobe rise.
REQ-007 Port: rd_addr  in  4  instruction fetch address from the core (pc).
REQ-008 Port: rd_data  out  8  instruction word at rd_addr.
REQ-009 Port: core_run  out  1  1 = core may execute; 0 = core holds pc at 0.
REQ-010 Port: busy  out  1  1 while clearing or loading.
REQ-011 Port: prog_len  out  5  words written in the current or most recent load, 0..16.
REQ-012 Port: ovf_err  out  1  sticky; set when a nibble arrives after 16 words are loaded.

Function
REQ-013 load_req and nib_strobe SHALL each pass through a 2-flop synchronizer; a strobe event is a 0->1 transition of the synchronized strobe, one cycle wide.
REQ-014 nib_data SHALL be sampled in the cycle the strobe event is detected.
REQ-015 States SHALL be CLEAR, RUN, LO, HI; busy = (state != RUN); core_run = (state == RUN).
REQ-016 CLEAR: write 8'h00 to mem[wr_ptr] each cycle, wr_ptr 0..15, then go to RUN with wr_ptr = 0; duration exactly 16 cycles.
REQ-017 RUN: if synchronized load_req = 1, go to LO and clear wr_ptr, prog_len and ovf_err to 0.
REQ-018 LO: on strobe event latch nibble as low half and go to HI; if prog_len = 16, set ovf_err instead, discard the nibble, stay in LO.
REQ-019 HI: on strobe event write {nib_data, low half} to mem[wr_ptr], increment prog_len, increment wr_ptr saturating at 15, go to LO.
REQ-020 In LO or HI, synchronized load_req = 0 SHALL return to RUN next cycle; a pending low half in HI is discarded.
REQ-021 If load_req = 0 and a strobe event occur in the same cycle, exit wins; the nibble is dropped and memory is unchanged.
REQ-022 Locations at or beyond prog_len SHALL keep their previous contents after a load.
REQ-023 rd_data = mem[rd_addr] when core_run = 1, else 8'h00, combinational from rd_addr.
REQ-024 Memory SHALL have a single write port; no reads or writes other than REQ-016/019 modify it.
REQ-025 Strobe events in RUN or CLEAR SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force state = CLEAR, wr_ptr = 0, prog_len = 0, ovf_err = 0, synchronizer flops = 0, busy = 1, core_run = 0, rd_data = 8'h00.
REQ-027 Reset asserted mid-load SHALL abort the load; after release CLEAR zeroes all 16 words before RUN.
REQ-028 Memory array itself SHALL have no reset; CLEAR provides initialization.

Verification
REQ-029 Release reset, idle pins -> busy = 1 for 16 cycles, then core_run = 1, every rd_addr returns 8'h00, prog_len = 0.
REQ-030 load_req = 1, nibbles B,1,7,1 then load_req = 0 -> mem[0] = 8'h1B, mem[1] = 8'h17, prog_len = 2, core_run returns to 1 within 3 cycles of pin fall.
REQ-031 Load 33 nibbles -> 16 words written, prog_len = 16, ovf_err = 1, mem[15] holds the 32nd/31st nibble pair, extra nibble not stored.
REQ-032 Load 3 nibbles (A,5,C) then drop load_req -> mem[0] = 8'h5A, mem[1] unchanged, prog_len = 1.
REQ-033 Assert rst_n = 0 after 2 nibbles of a load -> outputs at reset values asynchronously; after release all words read 8'h00.
REQ-034 Strobe pulses with load_req = 0 -> memory, prog_len and ovf_err unchanged, core_run stays 1.
